// File: rtl/mips32_pkg.sv
// Shared definitions for the pipelined MIPS32 subset core: opcodes, field
// positions, instruction classes and pipeline register layouts.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT,
    NOP
  } itype_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] npc;
  } ifid_t;

  typedef struct packed {
    logic        valid;
    itype_t      itype;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
  } idex_t;

  typedef struct packed {
    logic        valid;
    itype_t      itype;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] b;
  } exmem_t;

  typedef struct packed {
    logic        valid;
    itype_t      itype;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] lmd;
  } memwb_t;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, ir: 32'd0, npc: 32'd0};

  localparam idex_t IDEX_BUBBLE = '{valid: 1'b0, itype: NOP, op: 6'd0, rs: 5'd0,
                                    rt: 5'd0, dest: 5'd0, a: 32'd0, b: 32'd0,
                                    imm: 32'd0, npc: 32'd0};

  localparam exmem_t EXMEM_BUBBLE = '{valid: 1'b0, itype: NOP, dest: 5'd0,
                                      alu: 32'd0, b: 32'd0};

  localparam memwb_t MEMWB_BUBBLE = '{valid: 1'b0, itype: NOP, dest: 5'd0,
                                      alu: 32'd0, lmd: 32'd0};

  // Unlisted opcodes fall through to NOP so they flow harmlessly down the pipe.
  function automatic itype_t decode_type(input logic [5:0] op);
    itype_t t;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
      OP_LW:                                         t = LOAD;
      OP_SW:                                         t = STORE;
      OP_BNEQZ, OP_BEQZ:                             t = BRANCH;
      OP_HLT:                                        t = HALT;
      default:                                       t = NOP;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU; load/store/branch opcodes fall into the default add
// path, which produces the effective address.
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = a + b;
    case (op)
      OP_SUB, OP_SUBI: result = a - b;
      OP_AND:          result = a & b;
      OP_OR:           result = a | b;
      OP_SLT, OP_SLTI: result = {31'd0, ($signed(a) < $signed(b))};
      OP_MUL:          result = a * b;
      default:         result = a + b;
    endcase
  end

endmodule

// File: rtl/pipe_mips32.sv
// Five-stage MIPS32-subset core with a unified word-addressed memory,
// full EX forwarding, branch resolution in EX and a draining halt.
module pipe_mips32
  import mips32_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input logic clk,
  input logic rst_n
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  ifid_t  if_id;
  idex_t  id_ex;
  exmem_t ex_mem;
  memwb_t mem_wb;

  logic        wb_we;
  logic [31:0] wb_val;

  logic [5:0]  id_op;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_dest;
  itype_t      id_type;
  logic [31:0] id_a;
  logic [31:0] id_b;
  logic [31:0] id_imm;

  logic        exmem_fwd;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fetch_stop;

  always_comb begin
    wb_we  = mem_wb.valid && (mem_wb.itype inside {RR_ALU, RM_ALU, LOAD}) &&
             (mem_wb.dest != 5'd0) && !HALTED;
    wb_val = (mem_wb.itype == LOAD) ? mem_wb.lmd : mem_wb.alu;
  end

  // Register reads see a same-cycle writeback, so the file behaves write-before-read.
  always_comb begin
    id_op   = if_id.ir[OP_HI:OP_LO];
    id_rs   = if_id.ir[RS_HI:RS_LO];
    id_rt   = if_id.ir[RT_HI:RT_LO];
    id_rd   = if_id.ir[RD_HI:RD_LO];
    id_imm  = {{16{if_id.ir[IMM_HI]}}, if_id.ir[IMM_HI:IMM_LO]};
    id_type = if_id.valid ? decode_type(id_op) : NOP;

    if (id_rs == 5'd0)                          id_a = 32'd0;
    else if (wb_we && (mem_wb.dest == id_rs))   id_a = wb_val;
    else                                        id_a = Reg[id_rs];

    if (id_rt == 5'd0)                          id_b = 32'd0;
    else if (wb_we && (mem_wb.dest == id_rt))   id_b = wb_val;
    else                                        id_b = Reg[id_rt];

    case (id_type)
      RR_ALU:       id_dest = id_rd;
      RM_ALU, LOAD: id_dest = id_rt;
      default:      id_dest = 5'd0;
    endcase
  end

  // EX/MEM only forwards ALU results; a load there is deliberately invisible,
  // so an immediate consumer sees the pre-load value.
  always_comb begin
    exmem_fwd = ex_mem.valid && (ex_mem.itype inside {RR_ALU, RM_ALU}) &&
                (ex_mem.dest != 5'd0);

    ex_a = id_ex.a;
    if (wb_we && (mem_wb.dest == id_ex.rs))      ex_a = wb_val;
    if (exmem_fwd && (ex_mem.dest == id_ex.rs))  ex_a = ex_mem.alu;

    ex_b = id_ex.b;
    if (wb_we && (mem_wb.dest == id_ex.rt))      ex_b = wb_val;
    if (exmem_fwd && (ex_mem.dest == id_ex.rt))  ex_b = ex_mem.alu;

    alu_b     = (id_ex.itype == RR_ALU) ? ex_b : id_ex.imm;
    br_target = id_ex.npc + id_ex.imm;
    br_taken  = id_ex.valid && (id_ex.itype == BRANCH) &&
                ((id_ex.op == OP_BEQZ) ? (ex_a == 32'd0) : (ex_a != 32'd0));
  end

  mips32_alu u_alu (
    .op     (id_ex.op),
    .a      (ex_a),
    .b      (alu_b),
    .result (alu_y)
  );

  // Fetch stays off from the moment HLT is decoded until reset.
  always_comb begin
    fetch_stop = HALTED ||
                 (id_type == HALT) ||
                 (id_ex.valid  && (id_ex.itype  == HALT)) ||
                 (ex_mem.valid && (ex_mem.itype == HALT)) ||
                 (mem_wb.valid && (mem_wb.itype == HALT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= 32'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      if_id        <= IFID_BUBBLE;
      id_ex        <= IDEX_BUBBLE;
      ex_mem       <= EXMEM_BUBBLE;
      mem_wb       <= MEMWB_BUBBLE;
    end else begin
      TAKEN_BRANCH <= br_taken;
      if (mem_wb.valid && (mem_wb.itype == HALT)) HALTED <= 1'b1;

      if (br_taken) begin
        PC    <= br_target;
        if_id <= IFID_BUBBLE;
      end else if (fetch_stop) begin
        if_id <= IFID_BUBBLE;
      end else begin
        if_id <= '{valid: 1'b1, ir: Mem[PC[AW-1:0]], npc: PC + 32'd1};
        PC    <= PC + 32'd1;
      end

      if (br_taken) begin
        id_ex <= IDEX_BUBBLE;
      end else begin
        id_ex <= '{valid: if_id.valid, itype: id_type, op: id_op, rs: id_rs,
                   rt: id_rt, dest: id_dest, a: id_a, b: id_b, imm: id_imm,
                   npc: if_id.npc};
      end

      ex_mem <= '{valid: id_ex.valid, itype: id_ex.itype, dest: id_ex.dest,
                  alu: alu_y, b: ex_b};

      mem_wb <= '{valid: ex_mem.valid, itype: ex_mem.itype, dest: ex_mem.dest,
                  alu: ex_mem.alu, lmd: Mem[ex_mem.alu[AW-1:0]]};
    end
  end

  // Storage arrays have no reset so contents survive reset and can be preloaded.
  always_ff @(posedge clk) begin
    if (wb_we) Reg[mem_wb.dest] <= wb_val;
  end

  always_ff @(posedge clk) begin
    if (ex_mem.valid && (ex_mem.itype == STORE) && !HALTED)
      Mem[ex_mem.alu[AW-1:0]] <= ex_mem.b;
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed program-level bench for pipe_mips32: preloads Reg/Mem during reset,
// runs each program to HLT and compares architectural state against hand values.
module tb_pipe_mips32;
  import mips32_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int          hc;
  int          tc;
  logic [31:0] pv;

  pipe_mips32 #(.MEM_WORDS(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] encR(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Releases reset, then runs until HALTED (plus two cycles) or the budget expires.
  task automatic applyStimulus(input int budget, input int probeCycle,
                               output int haltCycle, output int takenCount,
                               output logic [31:0] probeR2);
    haltCycle  = -1;
    takenCount = 0;
    probeR2    = 32'hx;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk);
      #1;
      if (dut.TAKEN_BRANCH) takenCount++;
      if (cyc == probeCycle) probeR2 = dut.Reg[2];
      if (dut.HALTED && (haltCycle < 0)) haltCycle = cyc;
      if ((haltCycle >= 0) && (cyc >= haltCycle + 2)) break;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    checkOutput("reset_pc", dut.PC, 32'd0);
    checkOutput("reset_halted", {31'd0, dut.HALTED}, 32'd0);
    checkOutput("reset_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    // Load/forward/store program
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
    dut.Mem[120] = 32'd85;
    dut.Mem[0] = encI(OP_ADDI, 5'd0, 5'd1, 16'd120);
    dut.Mem[1] = encR(OP_OR, 5'd3, 5'd3, 5'd3);
    dut.Mem[2] = encI(OP_LW, 5'd1, 5'd2, 16'd0);
    dut.Mem[3] = encR(OP_OR, 5'd7, 5'd7, 5'd7);
    dut.Mem[4] = encI(OP_ADDI, 5'd2, 5'd2, 16'd45);
    dut.Mem[5] = encR(OP_OR, 5'd7, 5'd7, 5'd7);
    dut.Mem[6] = encI(OP_SW, 5'd1, 5'd2, 16'd1);
    dut.Mem[7] = {OP_HLT, 26'd0};
    applyStimulus(80, 0, hc, tc, pv);
    checkOutput("t1_mem121", dut.Mem[121], 32'd130);
    checkOutput("t1_mem120", dut.Mem[120], 32'd85);
    checkOutput("t1_halted", {31'd0, dut.HALTED}, 32'd1);
    checkOutput("t1_r1", dut.Reg[1], 32'd120);
    checkOutput("t1_r2", dut.Reg[2], 32'd130);
    checkOutput("t1_pc", dut.PC, 32'd8);
    checkOutput("t1_halt_cycle", hc, 32'd12);

    // Back-to-back dependent ALU ops
    rst_n = 1'b0;
    @(negedge clk);
    dut.Reg[1] = 32'd10;
    dut.Reg[2] = 32'd20;
    dut.Reg[3] = 32'hdead;
    dut.Reg[4] = 32'hdead;
    dut.Reg[5] = 32'hdead;
    dut.Mem[0] = encR(OP_ADD, 5'd1, 5'd2, 5'd3);
    dut.Mem[1] = encR(OP_MUL, 5'd3, 5'd3, 5'd4);
    dut.Mem[2] = encR(OP_SUB, 5'd4, 5'd1, 5'd5);
    dut.Mem[3] = {OP_HLT, 26'd0};
    applyStimulus(80, 0, hc, tc, pv);
    checkOutput("t2_r3", dut.Reg[3], 32'd30);
    checkOutput("t2_r4", dut.Reg[4], 32'd900);
    checkOutput("t2_r5", dut.Reg[5], 32'd890);

    // Countdown loop with taken branches
    rst_n = 1'b0;
    @(negedge clk);
    dut.Reg[1] = 32'd3;
    dut.Reg[2] = 32'd99;
    dut.Mem[0] = encI(OP_SUBI, 5'd1, 5'd1, 16'd1);
    dut.Mem[1] = encI(OP_BNEQZ, 5'd1, 5'd0, 16'hfffe);
    dut.Mem[2] = encI(OP_ADDI, 5'd0, 5'd2, 16'd7);
    dut.Mem[3] = {OP_HLT, 26'd0};
    applyStimulus(100, 14, hc, tc, pv);
    checkOutput("t3_r1", dut.Reg[1], 32'd0);
    checkOutput("t3_r2", dut.Reg[2], 32'd7);
    checkOutput("t3_taken_pulses", tc, 32'd2);
    checkOutput("t3_r2_before_wb", pv, 32'd99);
    checkOutput("t3_halt_cycle", hc, 32'd16);

    // R0 stays zero and is never forwarded
    rst_n = 1'b0;
    @(negedge clk);
    dut.Reg[0] = 32'd0;
    dut.Reg[6] = 32'd55;
    dut.Reg[7] = 32'd55;
    dut.Mem[0] = encI(OP_ADDI, 5'd0, 5'd0, 16'd5);
    dut.Mem[1] = encI(OP_SLTI, 5'd0, 5'd6, 16'hffff);
    dut.Mem[2] = encI(OP_ADDI, 5'd0, 5'd0, 16'd5);
    dut.Mem[3] = encI(OP_SLTI, 5'd0, 5'd7, 16'd1);
    dut.Mem[4] = {OP_HLT, 26'd0};
    applyStimulus(80, 0, hc, tc, pv);
    checkOutput("t4_r0", dut.Reg[0], 32'd0);
    checkOutput("t4_r6", dut.Reg[6], 32'd0);
    checkOutput("t4_r7", dut.Reg[7], 32'd1);

    // HLT followed by a store that must never happen
    rst_n = 1'b0;
    @(negedge clk);
    dut.Reg[2] = 32'h1234;
    dut.Mem[0] = {OP_HLT, 26'd0};
    dut.Mem[1] = encI(OP_SW, 5'd0, 5'd2, 16'd0);
    applyStimulus(40, 0, hc, tc, pv);
    checkOutput("t5_halted", {31'd0, dut.HALTED}, 32'd1);
    checkOutput("t5_mem0", dut.Mem[0], {OP_HLT, 26'd0});
    checkOutput("t5_pc", dut.PC, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t5_pc_frozen", dut.PC, 32'd1);

    // Asynchronous reset while halted, then mid-program
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_halted_cleared", {31'd0, dut.HALTED}, 32'd0);
    checkOutput("t6_pc_async", dut.PC, 32'd0);
    dut.Reg[9] = 32'd0;
    dut.Mem[60] = 32'hdead;
    dut.Mem[0] = encI(OP_ADDI, 5'd0, 5'd9, 16'd11);
    dut.Mem[1] = encR(OP_OR, 5'd7, 5'd7, 5'd7);
    dut.Mem[2] = encR(OP_OR, 5'd7, 5'd7, 5'd7);
    dut.Mem[3] = encR(OP_OR, 5'd7, 5'd7, 5'd7);
    dut.Mem[4] = encI(OP_SW, 5'd0, 5'd9, 16'd60);
    dut.Mem[5] = {OP_HLT, 26'd0};
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_pc_midrun", dut.PC, 32'd0);
    checkOutput("t6_taken_midrun", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_r9_kept", dut.Reg[9], 32'd11);
    checkOutput("t6_store_dropped", dut.Mem[60], 32'hdead);
    checkOutput("t6_mem_kept", dut.Mem[4], encI(OP_SW, 5'd0, 5'd9, 16'd60));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_pc_restart", dut.PC, 32'd1);
    checkOutput("t6_running", {31'd0, dut.HALTED}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
